// File: rtl/rx_beam_pkg.sv
// Shared types and the steering delay table for the receive beam scan controller.
package rx_beam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DWELL   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int NUM_CH_DEF     = 4;
  localparam int DELAY_W_DEF    = 5;
  localparam int NUM_ANGLES_DEF = 16;

  // Linear steering: the positive half delays higher channels, the negative half lower ones.
  function automatic int delay_for_angle(input int k, input int ch,
                                         input int num_ch = NUM_CH_DEF,
                                         input int num_angles = NUM_ANGLES_DEF);
    int s;
    s = k - num_angles / 2;
    if (s >= 0) begin
      return ch * s;
    end else begin
      return (num_ch - 1 - ch) * (-s);
    end
  endfunction

endpackage

// File: rtl/rx_delay_lut.sv
// Combinational map from steering angle index to the per-channel beamformer delays.
module rx_delay_lut
  import rx_beam_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int NUM_ANGLES = NUM_ANGLES_DEF,
  parameter int DELAY_W    = DELAY_W_DEF
) (
  input  logic [$clog2(NUM_ANGLES)-1:0]    i_angle,
  output logic [NUM_CH-1:0][DELAY_W-1:0]   o_delay
);

  always_comb begin
    o_delay = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      o_delay[ch] = DELAY_W'(delay_for_angle(int'(i_angle), ch, NUM_CH, NUM_ANGLES));
    end
  end

endmodule

// File: rtl/rx_beam_scan_ctrl.sv
// Sweeps steering angles, integrates |beamformer output| per angle and reports
// the angle with the highest energy as the coarse target bearing.
module rx_beam_scan_ctrl
  import rx_beam_pkg::*;
#(
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int NUM_ANGLES     = NUM_ANGLES_DEF,
  parameter int DELAY_W        = DELAY_W_DEF,
  parameter int SAMPLE_W       = 16,
  parameter int SETTLE_SAMPLES = 32,
  parameter int DWELL_SAMPLES  = 256,
  parameter int ENERGY_W       = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              sample_valid,
  input  logic signed [SAMPLE_W-1:0]        bf_sample,
  output logic [NUM_CH-1:0][DELAY_W-1:0]    delay_out,
  output logic                              delay_load,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NUM_ANGLES)-1:0]     best_angle,
  output logic [ENERGY_W-1:0]               best_energy
);

  localparam int AW      = $clog2(NUM_ANGLES);
  localparam int MAG_W   = SAMPLE_W + 1;
  localparam int CNT_MAX = (DWELL_SAMPLES > SETTLE_SAMPLES) ? DWELL_SAMPLES : SETTLE_SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_SAMPLES - 1);
  localparam logic [AW-1:0]    LAST_ANGLE  = AW'(NUM_ANGLES - 1);

  if (ENERGY_W < SAMPLE_W + 1 + $clog2(DWELL_SAMPLES)) begin : g_energy_w_check
    $error("ENERGY_W cannot hold DWELL_SAMPLES worth of |bf_sample|");
  end

  state_t                         r_state, w_next;
  logic [AW-1:0]                  r_angle, w_next_angle;
  logic [CNT_W-1:0]               r_cnt;
  logic [ENERGY_W-1:0]            r_acc, r_wbest_e, r_best_e, w_cand_e;
  logic [AW-1:0]                  r_wbest_a, r_best_a, w_cand_a;
  logic [NUM_CH-1:0][DELAY_W-1:0] r_delay, w_lut;
  logic                           r_delay_load, r_busy, r_done;
  logic [MAG_W-1:0]               w_ext, w_mag;
  logic                           w_better, w_last_angle;

  // Magnitude is one bit wider than the sample so the most negative code is exact.
  assign w_ext        = {bf_sample[SAMPLE_W-1], bf_sample};
  assign w_mag        = w_ext[SAMPLE_W] ? (~w_ext + MAG_W'(1)) : w_ext;
  assign w_better     = (r_acc > r_wbest_e);
  assign w_cand_e     = w_better ? r_acc : r_wbest_e;
  assign w_cand_a     = w_better ? r_angle : r_wbest_a;
  assign w_last_angle = (r_angle == LAST_ANGLE);

  // The table is addressed with the upcoming angle so delay_out changes on entry to LOAD.
  rx_delay_lut #(
    .NUM_CH     (NUM_CH),
    .NUM_ANGLES (NUM_ANGLES),
    .DELAY_W    (DELAY_W)
  ) u_lut (
    .i_angle (w_next_angle),
    .o_delay (w_lut)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_next_angle = r_angle;
    if (abort && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_next       = ST_LOAD;
            w_next_angle = '0;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_LOAD:   w_next = ST_SETTLE;
        ST_SETTLE: begin
          if (sample_valid && (r_cnt == SETTLE_LAST)) begin
            w_next = ST_DWELL;
          end else begin
            w_next = ST_SETTLE;
          end
        end
        ST_DWELL: begin
          if (sample_valid && (r_cnt == DWELL_LAST)) begin
            w_next = ST_COMPARE;
          end else begin
            w_next = ST_DWELL;
          end
        end
        ST_COMPARE: begin
          if (w_last_angle) begin
            w_next = ST_DONE;
          end else begin
            w_next       = ST_LOAD;
            w_next_angle = r_angle + AW'(1);
          end
        end
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Datapath: strobe counter, accumulator, working best and published result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_angle      <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_wbest_e    <= '0;
      r_wbest_a    <= '0;
      r_best_e     <= '0;
      r_best_a     <= '0;
      r_delay      <= '0;
      r_delay_load <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_angle      <= w_next_angle;
      r_busy       <= (w_next != ST_IDLE);
      r_delay_load <= (w_next == ST_LOAD);
      r_done       <= (w_next == ST_DONE);
      if (w_next == ST_LOAD) begin
        r_delay <= w_lut;
      end
      if ((r_state == ST_IDLE) && start) begin
        r_wbest_e <= '0;
        r_wbest_a <= '0;
      end else if (r_state == ST_COMPARE) begin
        r_wbest_e <= w_cand_e;
        r_wbest_a <= w_cand_a;
      end
      if ((r_state == ST_COMPARE) && (w_next == ST_DONE)) begin
        r_best_e <= w_cand_e;
        r_best_a <= w_cand_a;
      end
      if (r_state == ST_LOAD) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (sample_valid && ((r_state == ST_SETTLE) || (r_state == ST_DWELL))) begin
        if (((r_state == ST_SETTLE) && (r_cnt == SETTLE_LAST)) ||
            ((r_state == ST_DWELL) && (r_cnt == DWELL_LAST))) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (r_state == ST_DWELL) begin
          r_acc <= r_acc + ENERGY_W'(w_mag);
        end
      end
    end
  end

  assign delay_out   = r_delay;
  assign delay_load  = r_delay_load;
  assign busy        = r_busy;
  assign done        = r_done;
  assign best_angle  = r_best_a;
  assign best_energy = r_best_e;

endmodule

// File: tb/tb_rx_beam_scan_ctrl.sv
// Randomized bench for rx_beam_scan_ctrl against a sweep-level schedule/energy model.
module tb_rx_beam_scan_ctrl;

  localparam int NCH = 4, NANG = 16, DW = 5, SW = 16, SET = 4, DWL = 8, EW = 32;
  localparam int MAXC = 4000;
  localparam int PH_LOAD = 0, PH_SET = 1, PH_DWL = 2, PH_CMP = 3, PH_IDLE = 4;

  logic clk = 1'b0;
  logic rst_n, start, abort, sample_valid;
  logic signed [SW-1:0]   bf_sample;
  logic [NCH-1:0][DW-1:0] delay_out;
  logic delay_load, busy, done;
  logic [3:0]             best_angle;
  logic [EW-1:0]          best_energy;

  int n_checks = 0;
  int n_errors = 0;
  int prev_a = 0;
  longint prev_e = 0;

  bit                 vld  [MAXC];
  logic signed [15:0] dat  [MAXC];
  int                 phs  [MAXC];
  int                 angs [MAXC];

  always #5 clk = ~clk;

  rx_beam_scan_ctrl #(
    .NUM_CH(NCH), .NUM_ANGLES(NANG), .DELAY_W(DW), .SAMPLE_W(SW),
    .SETTLE_SAMPLES(SET), .DWELL_SAMPLES(DWL), .ENERGY_W(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sample_valid(sample_valid), .bf_sample(bf_sample),
    .delay_out(delay_out), .delay_load(delay_load), .busy(busy), .done(done),
    .best_angle(best_angle), .best_energy(best_energy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_delay(input int k, input int i);
    int s;
    s = k - NANG / 2;
    return (s >= 0) ? i * s : (NCH - 1 - i) * (-s);
  endfunction

  // mode: 0 const 100, 1 angle-11 burst, 2 -32768, 3 random data
  // vmode: 0 continuous, 1 every 3rd cycle, 2 random strobes
  // kill: 0 none, 1 abort, 2 reset, applied 2 cycles into kill_angle's dwell
  task automatic run_sweep(input int mode, input int vmode, input int kill,
                           input int kill_angle, input int extra_start);
    int j, c, kill_at, last_j, done_j, best_a, v, exp_pa;
    longint e [NANG];
    longint best_e, exp_pe;
    bit alive;
    for (int i = 0; i < MAXC; i++) begin
      case (vmode)
        0: vld[i] = 1'b1;
        1: vld[i] = (i % 3 == 0);
        default: vld[i] = ($urandom_range(0, 1) == 1);
      endcase
      phs[i] = PH_IDLE;
      angs[i] = 0;
    end
    j = 0;
    for (int a = 0; a < NANG; a++) begin
      phs[j] = PH_LOAD; angs[j] = a; j++;
      c = 0;
      while (c < SET && j < MAXC - 20) begin
        phs[j] = PH_SET; angs[j] = a;
        if (vld[j]) c++;
        j++;
      end
      c = 0;
      while (c < DWL && j < MAXC - 20) begin
        phs[j] = PH_DWL; angs[j] = a;
        if (vld[j]) c++;
        j++;
      end
      phs[j] = PH_CMP; angs[j] = a; j++;
    end
    done_j = j;
    for (int i = 0; i < MAXC; i++) begin
      case (mode)
        0: dat[i] = 16'sd100;
        1: dat[i] = (phs[i] == PH_DWL && angs[i] == 11) ? 16'sd1000 : 16'sd10;
        2: dat[i] = 16'sh8000;
        default: dat[i] = 16'($urandom);
      endcase
    end
    for (int a = 0; a < NANG; a++) e[a] = 0;
    for (int i = 0; i < done_j; i++) begin
      if (phs[i] == PH_DWL && vld[i]) begin
        v = int'(dat[i]);
        e[angs[i]] += (v < 0) ? -v : v;
      end
    end
    best_e = 0; best_a = 0;
    for (int a = 0; a < NANG; a++) begin
      if (e[a] > best_e) begin best_e = e[a]; best_a = a; end
    end
    kill_at = -1;
    if (kill != 0) begin
      for (int i = done_j - 1; i >= 0; i--)
        if (phs[i] == PH_DWL && angs[i] == kill_angle) kill_at = i + 2;
    end
    last_j = (kill_at >= 0) ? kill_at + 8 : done_j + 3;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (j = 0; j <= last_j; j++) begin
      alive = (kill_at < 0) || (j <= kill_at);
      check_eq($sformatf("busy j%0d", j), busy, alive && (j <= done_j));
      check_eq($sformatf("delay_load j%0d", j), delay_load, alive && phs[j] == PH_LOAD);
      check_eq($sformatf("done j%0d", j), done, (kill_at < 0) && (j == done_j));
      if (alive && phs[j] == PH_LOAD)
        for (int i = 0; i < NCH; i++)
          check_eq($sformatf("delay a%0d ch%0d", angs[j], i), delay_out[i], exp_delay(angs[j], i));
      if (kill == 2 && j == kill_at + 1)
        check_eq("delay_out after reset", delay_out, 0);
      if (kill_at < 0 && j >= done_j) begin exp_pa = best_a; exp_pe = best_e; end
      else if (kill == 2 && j > kill_at) begin exp_pa = 0; exp_pe = 0; end
      else begin exp_pa = prev_a; exp_pe = prev_e; end
      check_eq($sformatf("best_angle j%0d", j), best_angle, exp_pa);
      check_eq($sformatf("best_energy j%0d", j), best_energy, exp_pe);
      sample_valid = vld[j];
      bf_sample    = dat[j];
      start        = (j == extra_start);
      abort        = (kill == 1 && j == kill_at);
      rst_n        = !(kill == 2 && j == kill_at);
      @(negedge clk);
    end
    sample_valid = 1'b0; start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    if (kill == 0) begin prev_a = best_a; prev_e = best_e; end
    else if (kill == 2) begin prev_a = 0; prev_e = 0; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sample_valid = 1'b0; bf_sample = '0;
    repeat (3) @(negedge clk);
    check_eq("rst delay_out", delay_out, 0);
    check_eq("rst delay_load", delay_load, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst best_angle", best_angle, 0);
    check_eq("rst best_energy", best_energy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, 0, 0, 0, -1);   // all ties -> angle 0, 800
    run_sweep(1, 0, 0, 0, -1);   // burst on angle 11
    run_sweep(2, 0, 0, 0, -1);   // most negative sample
    run_sweep(3, 2, 0, 0, -1);   // random data and strobes
    run_sweep(3, 0, 1, 5, -1);   // abort in angle 5 dwell
    run_sweep(3, 0, 0, 0, -1);   // normal sweep after abort
    run_sweep(0, 1, 0, 0, 40);   // gapped strobes, start while busy
    run_sweep(3, 2, 2, 2, -1);   // reset in angle 2 dwell
    run_sweep(3, 1, 0, 0, -1);   // recovery after reset
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
